// File: rtl/fft_in_seq.sv
// fft_in_seq: input sequencer in front of a 4-to-1 serial-to-parallel stage.
// Accepts one complex sample per cycle from upstream, numbers it within the
// frame, forwards it one cycle later and flags each completed 4-sample group.
// Optional feature: define FFT_IN_SEQ_FRAME_CNT_EN to enable the
// completed-frame counter on frame_cnt (tied to zero otherwise).
module fft_in_seq #(
  parameter int NB        = 16,
  parameter int FRAME_LEN = 32,
  localparam int SW       = $clog2(FRAME_LEN),
  localparam int GW       = $clog2(FRAME_LEN / 4)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          en,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NB-1:0] in_dr,
  input  logic [NB-1:0] in_di,
  output logic          s2p_start,
  output logic [NB-1:0] s2p_dr,
  output logic [NB-1:0] s2p_di,
  input  logic          s2p_rdy,
  output logic          grp_valid,
  output logic [GW-1:0] grp_idx,
  output logic          frame_last,
  output logic          busy,
  output logic          underflow,
  output logic          sync_err,
  input  logic          clr_err,
  output logic [15:0]   frame_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [SW-1:0] LAST_IDX = SW'(FRAME_LEN - 1);
  localparam logic [GW-1:0] LAST_GRP = GW'(FRAME_LEN / 4 - 1);

  state_t        state, state_nxt;
  // sidx is the index of the slot handled this cycle; in RUN, sidx==0 marks
  // the frame boundary where a back-to-back start is possible.
  logic [SW-1:0] sidx, sidx_nxt;
  logic          in_ready_nxt;
  logic          slot;       // a sample slot is consumed this cycle
  logic          slot_zero;  // that slot is an underflow (zero sample)
  logic          start_ok;
  logic          iss_valid;  // s2p outputs carry a freshly issued sample
  logic [SW-1:0] iss_idx;
  logic          grp_hit;
  logic          sync_bad;

  assign start_ok = in_ready & en & in_valid;
  assign grp_hit  = iss_valid && (iss_idx[1:0] == 2'b11);
  // The stage must answer exactly on the group-0 grp_valid cycle.
  assign sync_bad = s2p_rdy != (grp_valid && (grp_idx == '0));

  // Next-state, slot-issue and ready decisions.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_nxt    = state;
    sidx_nxt     = sidx;
    in_ready_nxt = 1'b0;
    slot         = 1'b0;
    slot_zero    = 1'b0;
    case (state)
      IDLE: begin
        in_ready_nxt = en;
        if (start_ok) begin
          slot         = 1'b1;
          state_nxt    = RUN;
          sidx_nxt     = SW'(1);
          in_ready_nxt = 1'b1;
        end
      end
      RUN: begin
        if (sidx == '0) begin
          // Frame boundary: en gates whether the next frame follows directly.
          if (start_ok) begin
            slot         = 1'b1;
            sidx_nxt     = SW'(1);
            in_ready_nxt = 1'b1;
          end else begin
            state_nxt = DRAIN;
          end
        end else begin
          // Mid-frame: no stalls, a missing sample becomes a zero slot.
          slot      = 1'b1;
          slot_zero = ~in_valid;
          if (sidx == LAST_IDX) begin
            sidx_nxt     = '0;
            in_ready_nxt = en;
          end else begin
            sidx_nxt     = sidx + 1'b1;
            in_ready_nxt = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (frame_last) begin
          state_nxt    = IDLE;
          in_ready_nxt = en;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      sidx     <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state    <= state_nxt;
      sidx     <= sidx_nxt;
      in_ready <= in_ready_nxt;
      busy     <= (state_nxt != IDLE);
    end
  end

  // Sample issue to the serial-to-parallel stage; data holds between issues.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s2p_start <= 1'b0;
      s2p_dr    <= '0;
      s2p_di    <= '0;
      iss_valid <= 1'b0;
      iss_idx   <= '0;
    end else begin
      s2p_start <= slot && (sidx == '0);
      iss_valid <= slot;
      iss_idx   <= sidx;
      if (slot) begin
        s2p_dr <= slot_zero ? '0 : in_dr;
        s2p_di <= slot_zero ? '0 : in_di;
      end
    end
  end

  // Group qualification, one cycle behind the issue of each group's 4th sample.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      grp_valid  <= 1'b0;
      grp_idx    <= '0;
      frame_last <= 1'b0;
    end else begin
      grp_valid  <= grp_hit;
      frame_last <= grp_hit && (GW'(iss_idx >> 2) == LAST_GRP);
      if (grp_hit) grp_idx <= GW'(iss_idx >> 2);
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      underflow <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      underflow <= slot_zero | (underflow & ~clr_err);
      sync_err  <= sync_bad  | (sync_err  & ~clr_err);
    end
  end

`ifdef FFT_IN_SEQ_FRAME_CNT_EN
  // Completed-frame counter, wraps naturally at 16 bits.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)             frame_cnt <= '0;
    else if (frame_last) frame_cnt <= frame_cnt + 16'd1;
  end
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_fft_in_seq.sv
// tb_fft_in_seq: scoreboard bench for fft_in_seq (default parameters).
// Expected s2p issues and group events are queued with their due cycle when
// stimulus is driven; a negedge monitor pops and compares them.
module tb_fft_in_seq;

  localparam int NB = 16;
  localparam int FL = 32;
  localparam int GW = 3;
`ifdef FFT_IN_SEQ_FRAME_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          en = 1'b0;
  logic          in_valid = 1'b0;
  logic [NB-1:0] in_dr = '0;
  logic [NB-1:0] in_di = '0;
  logic          clr_err = 1'b0;
  logic          s2p_rdy;
  logic          in_ready, s2p_start, grp_valid, frame_last, busy, underflow, sync_err;
  logic [NB-1:0] s2p_dr, s2p_di;
  logic [GW-1:0] grp_idx;
  logic [15:0]   frame_cnt;

  // Model of the 4-to-1 stage: group 0 is ready 4 cycles after s2p_start.
  logic [3:0] start_sr;
  logic       rdy_force_hi = 1'b0;
  logic       rdy_withhold = 1'b0;
  assign s2p_rdy = (start_sr[3] & ~rdy_withhold) | rdy_force_hi;

  fft_in_seq #(.NB(NB), .FRAME_LEN(FL)) dut (
    .CLK(CLK), .RST(RST), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_dr(in_dr), .in_di(in_di), .s2p_start(s2p_start), .s2p_dr(s2p_dr),
    .s2p_di(s2p_di), .s2p_rdy(s2p_rdy), .grp_valid(grp_valid), .grp_idx(grp_idx),
    .frame_last(frame_last), .busy(busy), .underflow(underflow),
    .sync_err(sync_err), .clr_err(clr_err), .frame_cnt(frame_cnt)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK or posedge RST) begin
    if (RST) start_sr <= '0;
    else     start_sr <= {start_sr[2:0], s2p_start};
  end

  typedef struct { int due; logic [NB-1:0] dr; logic [NB-1:0] di; logic start; } s2p_exp_t;
  typedef struct { int due; logic [GW-1:0] idx; logic last; } grp_exp_t;

  s2p_exp_t sq[$];
  grp_exp_t gq[$];
  int n_tests = 0;
  int n_fail = 0;
  int slot = 0;
  int exp_frames = 0;

  function automatic logic [15:0] exp_cnt();
    return CNT_EN ? 16'(exp_frames) : 16'd0;
  endfunction

  // Monitor: compare due scoreboard entries and absence of unexpected pulses.
  always @(negedge CLK) begin
    if (!RST) begin
      logic     e_start, e_gv, e_last;
      s2p_exp_t se;
      grp_exp_t ge;
      e_start = 1'b0;
      e_gv    = 1'b0;
      e_last  = 1'b0;
      if (sq.size() > 0 && sq[0].due < cyc) begin
        se = sq.pop_front();
        n_tests++; n_fail++;
        $display("FAIL s2p_missed: issue due cycle %0d not seen (now %0d)", se.due, cyc);
      end
      if (sq.size() > 0 && sq[0].due == cyc) begin
        se = sq.pop_front();
        e_start = se.start;
        n_tests++;
        if (s2p_dr !== se.dr || s2p_di !== se.di) begin
          n_fail++;
          $display("FAIL s2p_data @%0d: got %h/%h expected %h/%h", cyc, s2p_dr, s2p_di, se.dr, se.di);
        end
      end
      n_tests++;
      if (s2p_start !== e_start) begin
        n_fail++;
        $display("FAIL s2p_start @%0d: got %b expected %b", cyc, s2p_start, e_start);
      end
      if (gq.size() > 0 && gq[0].due == cyc) begin
        ge = gq.pop_front();
        e_gv = 1'b1;
        e_last = ge.last;
        n_tests++;
        if (grp_idx !== ge.idx) begin
          n_fail++;
          $display("FAIL grp_idx @%0d: got %0d expected %0d", cyc, grp_idx, ge.idx);
        end
      end
      n_tests++;
      if (grp_valid !== e_gv || frame_last !== e_last) begin
        n_fail++;
        $display("FAIL grp_flags @%0d: got gv=%b last=%b expected gv=%b last=%b",
                 cyc, grp_valid, frame_last, e_gv, e_last);
      end
    end
  end

  // Drive one slot (real or missing sample) and queue its expected effects.
  task automatic do_slot(input bit v, input logic [NB-1:0] val);
    s2p_exp_t se;
    grp_exp_t ge;
    in_valid = v;
    in_dr    = val;
    in_di    = val ^ 16'h5A5A;
    se.due   = cyc + 1;
    se.dr    = v ? val : '0;
    se.di    = v ? (val ^ 16'h5A5A) : '0;
    se.start = (slot == 0);
    sq.push_back(se);
    if (slot % 4 == 3) begin
      ge.due  = cyc + 2;
      ge.idx  = GW'(slot / 4);
      ge.last = (slot == FL - 1);
      gq.push_back(ge);
      if (slot == FL - 1) exp_frames++;
    end
    slot = (slot + 1) % FL;
    @(negedge CLK);
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 10 && in_ready !== 1'b1; k++) @(negedge CLK);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_ready: in_ready=%b expected 1 within 10 cycles", in_ready);
    end
    slot = 0;
  endtask

  task automatic finish_frame(input string name);
    in_valid = 1'b0;
    repeat (3) @(negedge CLK);
    n_tests++;
    if (sq.size() != 0 || gq.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drained: pending s2p=%0d grp=%0d expected 0/0", name, sq.size(), gq.size());
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle_busy: got %b expected 0", name, busy);
    end
    n_tests++;
    if (frame_cnt !== exp_cnt()) begin
      n_fail++;
      $display("FAIL %s_frame_cnt: got %0d expected %0d", name, frame_cnt, exp_cnt());
    end
  endtask

  task automatic check_reset_vals(input string name);
    logic [2*NB+GW+24:0] act;
    act = {in_ready, s2p_start, s2p_dr, s2p_di, grp_valid, grp_idx, frame_last,
           busy, underflow, sync_err, frame_cnt};
    n_tests++;
    if (act !== '0) begin
      n_fail++;
      $display("FAIL %s: outputs %h expected all zero", name, act);
    end
  endtask

  task automatic test_reset();
    #1 RST = 1'b1;
    #1 check_reset_vals("reset_state");
    en = 1'b1;
    repeat (2) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b expected 0", in_ready);
    end
    @(negedge CLK);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_1cyc: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    en = 1'b1;
    wait_ready();
    for (int i = 0; i < FL; i++) do_slot(1'b1, 16'(i + 1));
    finish_frame("basic");
    n_tests++;
    if (underflow !== 1'b0 || sync_err !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_flags: got uf=%b sync=%b expected 0/0", underflow, sync_err);
    end
  endtask

  task automatic test_back_to_back();
    wait_ready();
    for (int i = 0; i < 2 * FL; i++) begin
      if (i >= 1) begin
        n_tests++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_busy slot %0d: got %b expected 1", i, busy);
        end
      end
      do_slot(1'b1, 16'(16'h0100 + i));
    end
    finish_frame("b2b");
  endtask

  task automatic test_underflow();
    wait_ready();
    for (int i = 0; i < FL; i++) begin
      if (i == 10 || i == 11) begin
        n_tests++;
        if (underflow !== (i == 11)) begin
          n_fail++;
          $display("FAIL uf_set slot %0d: got %b expected %b", i, underflow, i == 11);
        end
      end
      do_slot(i != 10, 16'(16'h0200 + i));
    end
    finish_frame("uf1");
    n_tests++;
    if (underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL uf_sticky: got %b expected 1", underflow);
    end
    clr_err = 1'b1;
    @(negedge CLK);
    clr_err = 1'b0;
    n_tests++;
    if (underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL uf_clear: got %b expected 0", underflow);
    end
    wait_ready();
    for (int i = 0; i < FL; i++) begin
      if (i == 9) clr_err = 1'b1;
      if (i == 4 || i == 10 || i == 11) begin
        n_tests++;
        if (underflow !== (i != 11)) begin
          n_fail++;
          $display("FAIL uf_clr_race slot %0d: got %b expected %b", i, underflow, i != 11);
        end
      end
      if (i == 11) clr_err = 1'b0;
      do_slot(i != 3 && i != 9, 16'(16'h0300 + i));
    end
    finish_frame("uf2");
  endtask

  task automatic test_sync();
    wait_ready();
    for (int i = 0; i < FL; i++) begin
      if (i == 5 || i == 7 || i == 17) begin
        n_tests++;
        if (sync_err !== 1'b0) begin
          n_fail++;
          $display("FAIL sync_quiet slot %0d: got %b expected 0", i, sync_err);
        end
      end
      if (i == 6 || i == 18) begin
        n_tests++;
        if (sync_err !== 1'b1) begin
          n_fail++;
          $display("FAIL sync_detect slot %0d: got %b expected 1", i, sync_err);
        end
      end
      rdy_withhold = (i == 5);
      rdy_force_hi = (i == 17);
      clr_err      = (i == 6);
      do_slot(1'b1, 16'(16'h0400 + i));
    end
    finish_frame("sync");
    clr_err = 1'b1;
    @(negedge CLK);
    clr_err = 1'b0;
    n_tests++;
    if (sync_err !== 1'b0) begin
      n_fail++;
      $display("FAIL sync_clear: got %b expected 0", sync_err);
    end
  endtask

  task automatic test_en_drop();
    en = 1'b1;
    wait_ready();
    for (int i = 0; i < FL; i++) begin
      if (i == 5) en = 1'b0;
      do_slot(1'b1, 16'(16'h0500 + i));
    end
    // Upstream keeps offering data; en=0 must keep the next frame from starting.
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (busy !== (k < 2) || (k >= 1 && in_ready !== 1'b0)) begin
        n_fail++;
        $display("FAIL en_drop_drain step %0d: got busy=%b rdy=%b expected busy=%b rdy=0",
                 k, busy, in_ready, k < 2);
      end
      @(negedge CLK);
    end
    finish_frame("en_drop");
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    en = 1'b1;
    wait_ready();
    for (int i = 0; i < 17; i++) do_slot(1'b1, 16'(16'h0600 + i));
    #2 RST = 1'b1;
    #1 check_reset_vals("reset_mid");
    sq.delete();
    gq.delete();
    in_valid   = 1'b0;
    slot       = 0;
    exp_frames = 0;
    @(negedge CLK);
    #2 RST = 1'b0;
    @(negedge CLK);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_ready: got %b expected 1", in_ready);
    end
    wait_ready();
    for (int i = 0; i < FL; i++) do_slot(1'b1, 16'(16'h0700 + i));
    finish_frame("reset_mid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_underflow();
    test_sync();
    test_en_drop();
    test_reset_mid();
    repeat (2) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
